// File: rtl/slap_pipe.sv
// Run-time selectable delay line: WIDTH-bit samples with per-stage valid bits,
// tap select 1..DEPTH, stall, synchronous flush and a registered occupancy count.
module slap_pipe #(
    parameter int              WIDTH   = 8,
    parameter int              DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int              SELW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SELW-1:0]  sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SELW-1:0]  count
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_d_q, stage_d_d;
    logic [DEPTH-1:0]            stage_v_q, stage_v_d;
    logic [SELW-1:0]             cnt_q, cnt_d;
    logic [SELW-1:0]             tap;

    always_comb begin
        stage_d_d = stage_d_q;
        stage_v_d = stage_v_q;
        cnt_d     = cnt_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) stage_d_d[i] = RST_VAL;
            stage_v_d = '0;
            cnt_d     = '0;
        end else if (en) begin
            stage_d_d[0] = in_data;
            stage_v_d[0] = in_valid;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d_d[i] = stage_d_q[i-1];
                stage_v_d[i] = stage_v_q[i-1];
            end
            // entry and exit on the same edge cancel, so cnt stays within 0..DEPTH
            cnt_d = cnt_q + SELW'(in_valid) - SELW'(stage_v_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_d_q[i] <= RST_VAL;
            stage_v_q <= '0;
            cnt_q     <= '0;
        end else begin
            stage_d_q <= stage_d_d;
            stage_v_q <= stage_v_d;
            cnt_q     <= cnt_d;
        end
    end

    // Clamp sel into 1..DEPTH and mux by compare so an illegal sel never indexes out of range.
    always_comb begin
        if (sel == '0)
            tap = '0;
        else if (sel > SELW'(DEPTH))
            tap = SELW'(DEPTH - 1);
        else
            tap = sel - SELW'(1);
        out_valid = 1'b0;
        out_data  = RST_VAL;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap == SELW'(i) && stage_v_q[i]) begin
                out_valid = 1'b1;
                out_data  = stage_d_q[i];
            end
        end
    end

    assign count = cnt_q;

endmodule

// File: tb/tb_slap_pipe.sv
// Bench for slap_pipe: scoreboard of due samples plus tables for tap latency and sel clamping.
module tb_slap_pipe;

    localparam int         WIDTH = 8;
    localparam int         DEPTH = 4;
    localparam int         SELW  = $clog2(DEPTH + 1);
    localparam logic [7:0] RV    = 8'h5A;

    logic             clk = 1'b0;
    logic             rst, en, flush, in_valid;
    logic [WIDTH-1:0] in_data;
    logic [SELW-1:0]  sel;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [SELW-1:0]  count;

    slap_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RV)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
        .in_data(in_data), .sel(sel), .out_valid(out_valid), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct { int due; logic [7:0] data; } sb_t;
    typedef struct { logic [SELW-1:0] sel; logic [7:0] data; } lat_vec_t;
    typedef struct { logic [SELW-1:0] sel; logic exp_v; logic [7:0] exp_d; } tap_vec_t;

    sb_t        sb[$];
    int         live[$];
    int         ecount = 0;
    int         tests  = 0;
    int         fails  = 0;
    logic       exp_v  = 1'b0;
    logic [7:0] exp_d  = RV;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic chk_out(input string nm);
        chk({nm, ".out_valid"}, 32'(out_valid), 32'(exp_v));
        chk({nm, ".out_data"}, 32'(out_data), 32'(exp_d));
        chk({nm, ".count"}, 32'(count), 32'(live.size()));
    endtask

    task automatic clear_model();
        sb.delete();
        live.delete();
        exp_v = 1'b0;
        exp_d = RV;
    endtask

    // One clock: drive, take the edge, update the expectation model, compare.
    task automatic step(input string nm, input logic e, input logic f, input logic iv,
                        input logic [7:0] d);
        en = e; flush = f; in_valid = iv; in_data = d;
        @(posedge clk);
        #1;
        if (f) begin
            clear_model();
        end else if (e) begin
            ecount++;
            if (iv) begin
                sb.push_back('{ecount + int'(sel) - 1, d});
                live.push_back(ecount);
            end
            while (live.size() > 0 && live[0] <= ecount - DEPTH) void'(live.pop_front());
            if (sb.size() > 0 && sb[0].due == ecount) begin
                exp_v = 1'b1;
                exp_d = sb[0].data;
                void'(sb.pop_front());
            end else begin
                exp_v = 1'b0;
                exp_d = RV;
            end
        end
        chk_out(nm);
    endtask

    lat_vec_t lat_tbl[4];
    tap_vec_t tap_tbl[6];

    initial begin
        lat_tbl[0] = '{3'd3, 8'h11};
        lat_tbl[1] = '{3'd1, 8'h21};
        lat_tbl[2] = '{3'd2, 8'h32};
        lat_tbl[3] = '{3'd4, 8'h44};
        // after injecting 10,11,12,13 the pipe holds 13 at stage 0 and 10 at stage 3
        tap_tbl[0] = '{3'd0, 1'b1, 8'h13};
        tap_tbl[1] = '{3'd7, 1'b1, 8'h10};
        tap_tbl[2] = '{3'd2, 1'b1, 8'h12};
        tap_tbl[3] = '{3'd5, 1'b1, 8'h10};
        tap_tbl[4] = '{3'd3, 1'b1, 8'h11};
        tap_tbl[5] = '{3'd1, 1'b1, 8'h13};

        // Reset held with live input
        rst = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hFF; sel = 3'd3;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_out("reset");
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b0;
        #1;
        chk_out("post_release");
        step("post_release_hold", 1'b0, 1'b0, 1'b1, 8'hFF);

        // Single-pulse latency at each tap
        for (int v = 0; v < 4; v++) begin
            sel = lat_tbl[v].sel;
            step("lat_flush", 1'b0, 1'b1, 1'b0, 8'h00);
            step("lat_inject", 1'b1, 1'b0, 1'b1, lat_tbl[v].data);
            for (int c = 0; c < 5; c++) step("lat_run", 1'b1, 1'b0, 1'b0, 8'h99);
        end

        // Stall: sample must wait for enabled edges, outputs hold meanwhile
        sel = 3'd2;
        step("stall_flush", 1'b0, 1'b1, 1'b0, 8'h00);
        step("stall_inject", 1'b1, 1'b0, 1'b1, 8'hA0);
        for (int c = 0; c < 3; c++) step("stall_hold", 1'b0, 1'b0, 1'b1, 8'hFF);
        step("stall_release", 1'b1, 1'b0, 1'b0, 8'h00);
        chk("stall_seen", 32'(out_data), 32'h0000_00A0);
        for (int c = 0; c < 2; c++) step("stall_hold_valid", 1'b0, 1'b0, 1'b1, 8'h55);
        step("stall_drain", 1'b1, 1'b0, 1'b0, 8'h00);

        // Full stream then drain
        sel = 3'd4;
        step("stream_flush", 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 1; i <= 8; i++) step("stream", 1'b1, 1'b0, 1'b1, 8'(i));
        chk("stream_full", 32'(count), 32'd4);
        for (int c = 0; c < 6; c++) step("drain", 1'b1, 1'b0, 1'b0, 8'hC3);
        chk("drain_empty", 32'(count), 32'd0);

        // Flush wins over simultaneous input
        for (int i = 0; i < 4; i++) step("fill", 1'b1, 1'b0, 1'b1, 8'h60 + 8'(i));
        chk("fill_full", 32'(count), 32'd4);
        step("flush_en", 1'b1, 1'b1, 1'b1, 8'hEE);
        for (int k = 1; k <= 4; k++) begin
            sel = 3'(k);
            #1;
            chk("flush_tap_valid", 32'(out_valid), 32'd0);
            chk("flush_tap_data", 32'(out_data), 32'(RV));
        end
        for (int c = 0; c < 5; c++) step("after_flush", 1'b1, 1'b0, 1'b0, 8'h00);

        // Asynchronous reset between edges
        sel = 3'd4;
        for (int i = 0; i < 4; i++) step("inflight", 1'b1, 1'b0, 1'b1, 8'h70 + 8'(i));
        #2;
        rst = 1'b1;
        #1;
        clear_model();
        chk_out("async_rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_out("async_release");
        step("post_rst_inject", 1'b1, 1'b0, 1'b1, 8'h77);
        for (int c = 0; c < 4; c++) step("post_rst_run", 1'b1, 1'b0, 1'b0, 8'h00);

        // Live tap change, including out-of-range sel
        sel = 3'd1;
        step("tap_flush", 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) step("tap_fill", 1'b1, 1'b0, 1'b1, 8'h10 + 8'(i));
        en = 1'b0;
        for (int v = 0; v < 6; v++) begin
            sel = tap_tbl[v].sel;
            #1;
            chk("tap_valid", 32'(out_valid), 32'(tap_tbl[v].exp_v));
            chk("tap_data", 32'(out_data), 32'(tap_tbl[v].exp_d));
            chk("tap_count", 32'(count), 32'd4);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/slap_pipe.md
# slap_pipe

Parametrised successor to the single-flop "slap" register. It delays a WIDTH-bit sample by a run-time selectable number of clock cycles, from 1 to DEPTH. Each stage carries a valid bit alongside its data. The pipe supports stall (`en`), synchronous flush and a live occupancy count. It is the general-purpose retiming/alignment delay line used wherever a datapath must be held back a known number of cycles to line up with a slower parallel path.

## Interface
- `WIDTH`, 8: data width in bits (≥1).
- `DEPTH`, 4: number of register stages (≥1).
- `RST_VAL`, 0: value loaded into every data stage on reset or flush; also the output data value when `out_valid`=0.
- `SELW`, $clog2(DEPTH+1): width of `sel` and `count` (derived, not overridden).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  advance: when 1, every stage shifts by one on the clock edge; when 0, all stages hold.
- `flush`  in  1  synchronous clear of all stages; takes priority over `en`.
- `in_valid`  in  1  input sample qualifier.
- `in_data`  in  WIDTH  input sample.
- `sel`  in  SELW  tap select, meaning delay in enabled cycles; legal range 1..DEPTH.
- `out_valid`  out  1  valid bit of the selected tap.
- `out_data`  out  WIDTH  data of the selected tap; equals RST_VAL when `out_valid`=0.
- `count`  out  SELW  number of stages (of all DEPTH) currently holding a valid sample.

## Operation
- Storage:
  - `stage_d[0..DEPTH-1]` holds WIDTH-bit data per stage.
  - `stage_v[0..DEPTH-1]` holds the valid bit per stage.
  - `cnt` is a registered counter of valid stages.
- Reset (`rst`=1, asynchronous): all `stage_d`=RST_VAL, all `stage_v`=0, `cnt`=0. Consequently `out_valid`=0, `out_data`=RST_VAL, `count`=0 while `rst` is high and immediately after its release.
- Priority per edge: `rst` > `flush` > `en` > hold.
- `flush`=1:
  - All `stage_v` are cleared to 0, all `stage_d` are set to RST_VAL, and `cnt` is set to 0.
  - The input presented on that edge is discarded, regardless of `en`.
- `en`=1, `flush`=0:
  - `stage_d[0]`<=`in_data`; `stage_v[0]`<=`in_valid`.
  - For i=1..DEPTH-1: `stage_d[i]`<=`stage_d[i-1]`; `stage_v[i]`<=`stage_v[i-1]`.
  - The sample in stage DEPTH-1 is dropped.
  - Data shifts even when its valid bit is 0; only the valid bit gives it meaning.
- `en`=0, `flush`=0: all registers hold. `in_valid`/`in_data` are ignored.
- Counter update on an enabled edge: `cnt` <= `cnt` + `in_valid` − `stage_v[DEPTH-1]`.
  - Simultaneous entry and exit leaves `cnt` unchanged.
  - `cnt` never exceeds DEPTH and never underflows.
  - Invariant checked by the bench: `count` == popcount(`stage_v`) at every edge.
- Tap mux (combinational from registers):
  - With k = `sel`: `out_valid`=`stage_v[k-1]`.
  - `out_data`=`stage_d[k-1]` if `out_valid` else RST_VAL.
- Out-of-range `sel`:
  - `sel`=0 is treated as 1.
  - `sel`>DEPTH is treated as DEPTH.
  - No X propagation in either case.
- `sel` change: takes effect combinationally in the same cycle. Stored samples are not moved, duplicated or lost; only the observed tap changes.

## Timing
- Latency: a sample accepted on an enabled edge appears at tap k after exactly k enabled edges. With `en` held at 1, this is k clock cycles.
- Stall: with `en`=0 cycles interleaved, latency stretches by the number of stalled edges. Output holds steady during a stall.
- Throughput: one sample per enabled cycle; no bubbles are inserted.
- Combinational paths:
  - `sel` → `out_valid`/`out_data`.
  - No path from `in_*`, `en` or `flush` to any output; all such effects appear one edge later.
- `count` is registered and reflects state after the most recent edge.
- Reset mid-stream: all in-flight samples are lost immediately, without waiting for a clock edge. The first sample after release follows the normal latency.
- Flush and en together: flush wins; `count`=0 and `out_valid`=0 after that edge.

## Test plan
- **Reset:**
  - Stimulus: WIDTH=8, DEPTH=4, RST_VAL=8'h5A. Hold `rst`=1 for 2 cycles, with `in_valid`=1 and `in_data`=8'hFF.
  - Required: `out_valid`=0, `out_data`=8'h5A and `count`=0 throughout, and after release before any enabled edge.
- **Latency per tap:**
  - Stimulus: `en`=1, `sel`=3. Drive the one-cycle pulse `in_valid`=1, `in_data`=8'h11 at edge 0.
  - Required: `out_valid`=1, `out_data`=8'h11 only in the cycle after edge 2 (the third edge). Repeat for `sel`=1, 2 and 4, each giving k-cycle latency.
- **Stall:**
  - Stimulus: `sel`=2. Inject 8'hA0 at edge 0, then `en`=0 for 3 cycles, then `en`=1.
  - Required: 8'hA0 appears after the second enabled edge, i.e. 5 cycles after injection. Output and `count`=1 hold steady during the stall.
- **Full stream and count:**
  - Stimulus: `en`=1, back-to-back `in_valid`=1 with data 1,2,3,...
  - Required: `count` ramps 1→2→3→4 and stays at 4. At `sel`=4, `out_data` reads 1,2,3,... consecutively.
  - Then drop `in_valid`: `count` decrements by one per cycle to 0.
- **Flush with simultaneous input:**
  - Stimulus: pipe full (`count`=4). Assert `flush`=1, `en`=1, `in_valid`=1, `in_data`=8'hEE for one edge.
  - Required: `count`=0 and `out_valid`=0 at every tap. 8'hEE never appears.
- **Asynchronous reset and live tap change:**
  - Stimulus: assert `rst` between edges while data is in flight.
  - Required: outputs are cleared before the next edge.
  - Stimulus: set `sel`=0, then `sel`=7 (DEPTH=4).
  - Required: these behave as 1 and 4, with no X on outputs.
